// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the two-port memory arbiter.
// Used by mem_port_arbiter and arb_watchdog.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int LINE_W_DEF  = 128;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } arb_side_t;

  // Decide whether D wins in IDLE; with rotation enabled the side that was
  // not granted last wins a tie, otherwise D always wins.
  function automatic logic pick_d(input logic i_req, input logic d_req,
                                  input logic rotate, input arb_side_t last);
    if (!d_req)
      pick_d = 1'b0;
    else if (!rotate || !i_req)
      pick_d = 1'b1;
    else
      pick_d = (last == SIDE_I);
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts stalled grant cycles and flags when the count
// reaches TIMEOUT. Counter is 8 bits and saturates.
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic run,
  input  logic hit,
  output logic expired
);

  localparam logic [7:0] LIMIT_M1 = 8'(TIMEOUT - 1);

  logic [7:0] count_reg;
  logic [7:0] count_next;
  logic       step;

  assign step = run & ~hit;

  always_comb begin
    count_next = count_reg;
    if (start)
      count_next = 8'd0;
    else if (step && count_reg != 8'hFF)
      count_next = count_reg + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count_reg <= 8'd0;
    else
      count_reg <= count_next;
  end

  // Pulses in the stalled cycle whose increment lands the count on TIMEOUT.
  assign expired = step & (count_reg == LIMIT_M1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an I-cache read port and a D-cache read/write port onto one
// backing-memory port. Define ARB_ROUND_ROBIN_EN for alternating tie-break.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_done,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  arb_state_t        state_reg;
  arb_state_t        state_next;
  logic              load_i;
  logic              load_d;
  logic              win_d;
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [LINE_W-1:0] mem_wdata_reg;
  logic              err_reg;
  logic              expired;

`ifdef ARB_ROUND_ROBIN_EN
  arb_side_t last_grant_reg;

  assign win_d = pick_d(i_req, d_req, 1'b1, last_grant_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_grant_reg <= SIDE_I;
    else if (load_d)
      last_grant_reg <= SIDE_D;
    else if (load_i)
      last_grant_reg <= SIDE_I;
  end
`else
  assign win_d = pick_d(i_req, d_req, 1'b0, SIDE_I);
`endif

  always_comb begin
    state_next = state_reg;
    load_i     = 1'b0;
    load_d     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_d) begin
          load_d     = 1'b1;
          state_next = GNT_D;
        end else if (i_req) begin
          load_i     = 1'b1;
          state_next = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_rdy)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Memory-side request fields are captured once at grant time so that
  // requester inputs may change freely while the grant is outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else if (load_d) begin
      mem_req_reg   <= 1'b1;
      mem_we_reg    <= d_we;
      mem_addr_reg  <= d_addr;
      mem_wdata_reg <= d_wdata;
    end else if (load_i) begin
      mem_req_reg   <= 1'b1;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= i_addr;
    end else if (busy && mem_rdy) begin
      mem_req_reg   <= 1'b0;
    end
  end

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (load_i | load_d),
    .run     (busy),
    .hit     (mem_rdy),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_reg <= 1'b0;
    else if (expired)
      err_reg <= 1'b1;
  end

  assign busy      = (state_reg != IDLE);
  assign i_done    = (state_reg == GNT_I) & mem_rdy;
  assign d_done    = (state_reg == GNT_D) & mem_rdy;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4); grant-order expectations
// follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;
  logic [LW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic          d_done;
  logic [LW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_rdy;
  logic [LW-1:0] mem_rdata;
  logic          busy;
  logic          err;

  int tests_run = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdy = 1'b0; mem_rdata = '0;
    tick(); tick();
    tests_run++;
    if ({busy, mem_req, mem_we, err, i_done, d_done} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags got %b expected 000000", {busy, mem_req, mem_we, err, i_done, d_done});
    end
    tests_run++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      fails++;
      $display("FAIL reset_regs addr %h wdata %h expected 0", mem_addr, mem_wdata);
    end
    reset_n = 1'b1;
    tick();
    $display("[TB] reset: busy=%b mem_req=%b err=%b", busy, mem_req, err);
  endtask

  task automatic test_lone_i();
    i_req = 1'b1; i_addr = 32'h100;
    tick();
    i_req = 1'b0;
    #1;
    tests_run++;
    if (mem_req !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
      fails++;
      $display("FAIL lone_grant req=%b busy=%b we=%b addr=%h expected 1 1 0 00000100", mem_req, busy, mem_we, mem_addr);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      tests_run++;
      if (mem_req !== 1'b1 || i_done !== 1'b0 || mem_we !== 1'b0) begin
        fails++;
        $display("FAIL lone_wait%0d req=%b done=%b we=%b expected 1 0 0", c, mem_req, i_done, mem_we);
      end
    end
    tick();
    mem_rdy = 1'b1; mem_rdata = {16{8'hA5}};
    #1;
    tests_run++;
    if (i_done !== 1'b1 || d_done !== 1'b0 || i_rdata !== {16{8'hA5}} || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL lone_done i_done=%b d_done=%b rdata=%h we=%b expected 1 0 a5.. 0", i_done, d_done, i_rdata, mem_we);
    end
    tick();
    mem_rdy = 1'b0;
    #1;
    tests_run++;
    if (i_done !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0 || mem_wdata !== '0) begin
      fails++;
      $display("FAIL lone_after done=%b req=%b busy=%b wdata=%h expected 0 0 0 0", i_done, mem_req, busy, mem_wdata);
    end
    $display("[TB] lone I read addr=100 done pulse checked");
  endtask

  task automatic test_contention_fixed();
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = {4{32'hDEADBEEF}};
    tick();
    d_req = 1'b0; d_addr = 32'hFFFF; d_wdata = '0; d_we = 1'b0;
    #1;
    tests_run++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== {4{32'hDEADBEEF}}) begin
      fails++;
      $display("FAIL cont_d_grant we=%b addr=%h wdata=%h expected 1 00000200 deadbeef..", mem_we, mem_addr, mem_wdata);
    end
    tick();
    mem_rdy = 1'b1;
    #1;
    tests_run++;
    if (d_done !== 1'b1 || i_done !== 1'b0 || mem_addr !== 32'h200) begin
      fails++;
      $display("FAIL cont_d_done d_done=%b i_done=%b addr=%h expected 1 0 00000200", d_done, i_done, mem_addr);
    end
    tick();
    mem_rdy = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL cont_idle_gap busy=%b req=%b expected 0 0", busy, mem_req);
    end
    tick();
    i_req = 1'b0;
    #1;
    tests_run++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h300 || mem_wdata !== {4{32'hDEADBEEF}}) begin
      fails++;
      $display("FAIL cont_i_grant req=%b we=%b addr=%h wdata=%h expected 1 0 00000300 deadbeef..", mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_rdy = 1'b1;
    #1;
    tests_run++;
    if (i_done !== 1'b1 || d_done !== 1'b0) begin
      fails++;
      $display("FAIL cont_i_done i_done=%b d_done=%b expected 1 0", i_done, d_done);
    end
    tick();
    mem_rdy = 1'b0;
    $display("[TB] contention: D(200) then I(300) checked");
  endtask

  task automatic test_hold_both();
    logic [AW-1:0] exp_addr [4];
`ifdef ARB_ROUND_ROBIN_EN
    exp_addr = '{32'h500, 32'h400, 32'h500, 32'h400};
`else
    exp_addr = '{32'h500, 32'h500, 32'h500, 32'h500};
`endif
    i_req = 1'b1; i_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (mem_addr !== exp_addr[k] || busy !== 1'b1) begin
        fails++;
        $display("FAIL hold_grant%0d addr=%h busy=%b expected %h 1", k, mem_addr, busy, exp_addr[k]);
      end
      mem_rdy = 1'b1;
      #1;
      tests_run++;
      if ({i_done, d_done} !== ((exp_addr[k] == 32'h500) ? 2'b01 : 2'b10)) begin
        fails++;
        $display("FAIL hold_done%0d i/d_done=%b%b for addr %h", k, i_done, d_done, exp_addr[k]);
      end
      tick();
      mem_rdy = 1'b0;
      $display("[TB] hold txn %0d granted addr=%h", k, exp_addr[k]);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_spurious_and_drop();
    mem_rdy = 1'b1;
    #1;
    tests_run++;
    if (i_done !== 1'b0 || d_done !== 1'b0) begin
      fails++;
      $display("FAIL spurious_done i_done=%b d_done=%b expected 0 0", i_done, d_done);
    end
    tick();
    mem_rdy = 1'b0;
    i_req = 1'b1; i_addr = 32'h600;
    #1;
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL spurious_busy got %b expected 0", busy);
    end
    tick();
    i_req = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b1 || mem_addr !== 32'h600) begin
      fails++;
      $display("FAIL drop_hold busy=%b addr=%h expected 1 00000600", busy, mem_addr);
    end
    mem_rdy = 1'b1;
    #1;
    tests_run++;
    if (i_done !== 1'b1) begin
      fails++;
      $display("FAIL drop_done i_done=%b expected 1", i_done);
    end
    tick();
    mem_rdy = 1'b0;
    $display("[TB] spurious rdy ignored, dropped req completed");
  endtask

  task automatic test_watchdog();
    tests_run++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL wd_pre err=%b expected 0", err);
    end
    i_req = 1'b1; i_addr = 32'h800;
    tick();
    i_req = 1'b0;
    tick(); tick();
    tests_run++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL wd_cycle3 err=%b expected 0", err);
    end
    tick(); tick();
    tests_run++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL wd_cycle5 err=%b busy=%b expected 1 1", err, busy);
    end
    tick(); tick();
    mem_rdy = 1'b1;
    #1;
    tests_run++;
    if (i_done !== 1'b1) begin
      fails++;
      $display("FAIL wd_done i_done=%b expected 1", i_done);
    end
    tick();
    mem_rdy = 1'b0;
    tick();
    tests_run++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL wd_sticky err=%b busy=%b expected 1 0", err, busy);
    end
    $display("[TB] watchdog err=%b after stalled grant", err);
  endtask

  task automatic test_mid_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h700; d_wdata = {4{32'h12345678}};
    tick();
    d_req = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || err !== 1'b0 || mem_addr !== '0) begin
      fails++;
      $display("FAIL midrst_drop busy=%b req=%b err=%b addr=%h expected 0 0 0 0", busy, mem_req, err, mem_addr);
    end
    mem_rdy = 1'b1;
    #1;
    tests_run++;
    if (d_done !== 1'b0) begin
      fails++;
      $display("FAIL midrst_done d_done=%b expected 0", d_done);
    end
    tick();
    mem_rdy = 1'b0;
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || d_done !== 1'b0) begin
      fails++;
      $display("FAIL midrst_idle busy=%b req=%b d_done=%b expected 0 0 0", busy, mem_req, d_done);
    end
    $display("[TB] mid-grant reset returned to idle");
  endtask

  initial begin
    test_reset();
    test_lone_i();
    test_contention_fixed();
    test_hold_both();
    test_spurious_and_drop();
    test_watchdog();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
